// File: rtl/dram_wb_arbiter_if.sv
// Bus bundle between the core-side Wishbone masters, the DRAM wrapper port and the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of whoever drives the requesters and wrapper.
interface dram_wb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int WORD_SIZE   = 256,
  parameter int ADDR_WIDTH  = 32
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  // Handshake: a requester raises cyc&stb with we/addr/data stable and holds them until it
  // sees its one-cycle ack or err bit; the wrapper side holds cyc/stb until its single-cycle ack.
  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS*WORD_SIZE-1:0]  m_data_i;
  logic [WORD_SIZE-1:0]              m_data_o;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;
  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_addr_o;
  logic [WORD_SIZE-1:0]              s_data_o;
  logic [WORD_SIZE-1:0]              s_data_i;
  logic                              s_ack_i;
  logic [IDX_W-1:0]                  grant_o;
  logic                              busy_o;
  logic [1:0]                        state_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    output m_data_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
           grant_o, busy_o, state_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    input  m_data_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o,
           grant_o, busy_o, state_o
  );
endinterface

// File: rtl/dram_wb_arbiter.sv
// Round-robin arbiter sharing the DRAM wrapper's Wishbone port, one transaction in flight.
// Define DRAM_ARB_TIMEOUT_EN to add the BUSY watchdog (m_err_o pulse, then DRAIN the late ack).
module dram_wb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int WORD_SIZE      = 256,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              sys_clk,
  input logic              rst,
  dram_wb_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_t;

  state_t                 state, state_n;
  logic [NUM_MASTERS-1:0] req;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       pick;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       grant_inc;
  logic                   any_req;
  logic                   tmo_hit;
  int                     sum;

  assign req          = bus.m_cyc_i & bus.m_stb_i;
  assign bus.state_o  = state;
  assign grant_inc    = (bus.grant_o == IDX_W'(NUM_MASTERS - 1)) ? '0 : bus.grant_o + 1'b1;

  // Walk downward so the last hit is the one nearest rr_ptr in the upward direction.
  always_comb begin
    pick    = rr_ptr;
    any_req = 1'b0;
    cand    = '0;
    sum     = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      sum = int'(rr_ptr) + i;
      if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
      cand = IDX_W'(sum);
      if (req[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = BUSY;
      BUSY: begin
        if (bus.s_ack_i)  state_n = IDLE;
        else if (tmo_hit) state_n = DRAIN;
      end
      DRAIN:   if (bus.s_ack_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      bus.grant_o  <= '0;
      bus.s_cyc_o  <= 1'b0;
      bus.s_stb_o  <= 1'b0;
      bus.s_we_o   <= 1'b0;
      bus.s_addr_o <= '0;
      bus.s_data_o <= '0;
      bus.m_data_o <= '0;
      bus.m_ack_o  <= '0;
      bus.busy_o   <= 1'b0;
    end else begin
      bus.m_ack_o <= '0;
      bus.busy_o  <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.grant_o  <= pick;
            bus.s_we_o   <= bus.m_we_i[pick];
            bus.s_addr_o <= bus.m_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
            bus.s_data_o <= bus.m_data_i[pick*WORD_SIZE +: WORD_SIZE];
            bus.s_cyc_o  <= 1'b1;
            bus.s_stb_o  <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.s_ack_i) begin
            bus.s_cyc_o  <= 1'b0;
            bus.s_stb_o  <= 1'b0;
            bus.m_data_o <= bus.s_data_i;
            // An abandoned request still completes downstream but gets no ack.
            if (bus.m_cyc_i[bus.grant_o]) bus.m_ack_o[bus.grant_o] <= 1'b1;
            rr_ptr <= grant_inc;
          end else if (tmo_hit) begin
            bus.s_cyc_o <= 1'b0;
            bus.s_stb_o <= 1'b0;
          end
        end
        DRAIN: if (bus.s_ack_i) rr_ptr <= grant_inc;
        default: ;
      endcase
    end
  end

`ifdef DRAM_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // A same-cycle ack beats the limit.
  assign tmo_hit = (state == BUSY) && !bus.s_ack_i && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      bus.m_err_o <= '0;
    end else begin
      bus.m_err_o <= '0;
      if (state != BUSY) tmo_cnt <= '0;
      else if (!tmo_hit) tmo_cnt <= tmo_cnt + 16'd1;
      if (tmo_hit) bus.m_err_o[bus.grant_o] <= 1'b1;
    end
  end
`else
  // Watchdog absent: BUSY waits for the ack indefinitely, the limit is not consulted.
  logic unused_tmo_limit;
  assign unused_tmo_limit = (TIMEOUT_CYCLES > 0);
  assign tmo_hit          = 1'b0;
  assign bus.m_err_o      = '0;
`endif
endmodule

// File: tb/tb_dram_wb_arbiter.sv
// Directed bench for dram_wb_arbiter: wrapper responder model, expected-queue scoreboard, summary.
module tb_dram_wb_arbiter;
  localparam int NM = 4;
  localparam int WS = 256;
  localparam int AW = 32;
  localparam int IW = 2;
`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  localparam int SW = IW + 1 + AW + WS;
  localparam int MW = 1 + NM + 1 + WS;

  logic sys_clk;
  logic rst;

  dram_wb_arbiter_if #(.NUM_MASTERS(NM), .WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

  dram_wb_arbiter #(
    .NUM_MASTERS(NM), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [SW-1:0] exp_s_q[$];
  logic [MW-1:0] exp_m_q[$];
  int ack_delay = 2;

  // ---------------- clock / reset ----------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [WS-1:0] rsp_for(input logic [AW-1:0] a);
    if (a == 32'h0000_0080) return {32{8'hA5}};
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  // ---------------- wrapper responder ----------------
  initial begin
    int  cnt;
    bit  pending;
    pending     = 1'b0;
    cnt         = 0;
    bus.s_ack_i = 1'b0;
    bus.s_data_i = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      bus.s_ack_i = 1'b0;
      if (pending) begin
        if (cnt <= 1) begin
          bus.s_ack_i  = 1'b1;
          bus.s_data_i = rsp_for(bus.s_addr_o);
          pending      = 1'b0;
        end else begin
          cnt--;
        end
      end else if (bus.s_stb_o) begin
        pending = 1'b1;
        cnt     = ack_delay;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [SW-1:0] cur_s;
  logic          stb_prev;
  logic [MW-1:0] m_e;
  logic [NM-1:0] e_ack, e_err;

  always @(negedge sys_clk) begin
    if (rst) begin
      stb_prev = 1'b0;
    end else begin
      if (bus.s_stb_o) begin
        if (!stb_prev) begin
          if (exp_s_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL s_unexpected got addr=%h we=%0b", bus.s_addr_o, bus.s_we_o);
            cur_s = '0;
          end else begin
            cur_s = exp_s_q.pop_front();
          end
        end
        checks++;
        if ({bus.grant_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o} !== cur_s || bus.s_cyc_o !== 1'b1) begin
          errors++;
          $display("FAIL s_req got g=%0d cyc=%0b we=%0b addr=%h data=%h exp g=%0d we=%0b addr=%h data=%h",
                   bus.grant_o, bus.s_cyc_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o,
                   cur_s[SW-1 -: IW], cur_s[WS+AW], cur_s[WS +: AW], cur_s[WS-1:0]);
        end
      end
      stb_prev = bus.s_stb_o;

      if ((bus.m_ack_o | bus.m_err_o) != '0) begin
        checks++;
        if (exp_m_q.size() == 0) begin
          errors++;
          $display("FAIL m_unexpected got ack=%b err=%b", bus.m_ack_o, bus.m_err_o);
        end else begin
          m_e   = exp_m_q.pop_front();
          e_ack = m_e[MW-1] ? '0 : m_e[MW-2 -: NM];
          e_err = m_e[MW-1] ? m_e[MW-2 -: NM] : '0;
          if (bus.m_ack_o !== e_ack || bus.m_err_o !== e_err ||
              (m_e[WS] && bus.m_data_o !== m_e[WS-1:0])) begin
            errors++;
            $display("FAIL m_resp got ack=%b err=%b data=%h exp ack=%b err=%b data=%h",
                     bus.m_ack_o, bus.m_err_o, bus.m_data_o, e_ack, e_err, m_e[WS-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge sys_clk);
    for (int i = 0; i < NM; i++) begin
      if (bus.m_ack_o[i] || bus.m_err_o[i]) begin
        bus.m_cyc_i[i] = 1'b0;
        bus.m_stb_i[i] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int i, input logic we, input logic [AW-1:0] a, input logic [WS-1:0] d);
    bus.m_we_i[i]          = we;
    bus.m_addr_i[i*AW +: AW] = a;
    bus.m_data_i[i*WS +: WS] = d;
    bus.m_cyc_i[i]         = 1'b1;
    bus.m_stb_i[i]         = 1'b1;
  endtask

  // kind: 0 read ack (data checked), 1 write ack, 2 no master response, 3 timeout err
  task automatic expect_txn(input int i, input logic we, input logic [AW-1:0] a,
                            input logic [WS-1:0] d, input int kind);
    logic [NM-1:0] v;
    v = '0;
    v[i] = 1'b1;
    exp_s_q.push_back({IW'(i), we, a, d});
    if (kind == 0) exp_m_q.push_back({1'b0, v, 1'b1, rsp_for(a)});
    if (kind == 1) exp_m_q.push_back({1'b0, v, 1'b0, {WS{1'b0}}});
    if (kind == 3) exp_m_q.push_back({1'b1, v, 1'b0, {WS{1'b0}}});
  endtask

  task automatic chk(input string name, input logic [WS-1:0] got, input logic [WS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((bus.m_cyc_i != '0 || bus.busy_o) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bus.m_cyc_i != '0 || bus.busy_o) begin
      errors++;
      $display("FAIL %s timeout cyc=%b busy=%0b", name, bus.m_cyc_i, bus.busy_o);
    end
  endtask

  task automatic wait_stb(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.s_stb_o && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.s_stb_o) begin
      errors++;
      $display("FAIL %s no s_stb_o within %0d cycles", name, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst          = 1'b1;
    bus.m_cyc_i  = '0;
    bus.m_stb_i  = '0;
    bus.m_we_i   = '0;
    bus.m_addr_i = '0;
    bus.m_data_i = '0;
    repeat (3) tick();
    chk("rst_s_stb", WS'(bus.s_stb_o), '0);
    chk("rst_s_cyc", WS'(bus.s_cyc_o), '0);
    chk("rst_m_ack", WS'(bus.m_ack_o), '0);
    chk("rst_busy", WS'(bus.busy_o), '0);
    chk("rst_state", WS'(bus.state_o), '0);
    rst = 1'b0;
    tick();

    // contention from rr_ptr=0: 0,1,2,3 then a new round starts at 0
    ack_delay = 2;
    for (int i = 0; i < NM; i++) begin
      issue(i, 1'b0, 32'h1000 + 32'(i) * 32'h40, '0);
      expect_txn(i, 1'b0, 32'h1000 + 32'(i) * 32'h40, '0, 0);
    end
    wait_idle("contention", 60);
    issue(0, 1'b0, 32'h1800, '0);
    issue(2, 1'b0, 32'h1880, '0);
    expect_txn(0, 1'b0, 32'h1800, '0, 0);
    expect_txn(2, 1'b0, 32'h1880, '0, 0);
    wait_idle("round2", 40);

    // rr_ptr=3: m3 before m0, leaving rr_ptr=1
    issue(0, 1'b0, 32'h2000, '0);
    issue(3, 1'b0, 32'h2300, '0);
    expect_txn(3, 1'b0, 32'h2300, '0, 0);
    expect_txn(0, 1'b0, 32'h2000, '0, 0);
    wait_idle("wrap", 40);

    // rr_ptr=1: m1 single read of 0x80 wins over m0
    ack_delay = 3;
    issue(0, 1'b0, 32'h2400, '0);
    issue(1, 1'b0, 32'h0000_0080, '0);
    expect_txn(1, 1'b0, 32'h0000_0080, '0, 0);
    expect_txn(0, 1'b0, 32'h2400, '0, 0);
    wait_idle("read80", 40);

    // write from m2
    issue(2, 1'b1, 32'h0000_0100, {8{32'hDEAD_BEEF}});
    expect_txn(2, 1'b1, 32'h0000_0100, {8{32'hDEAD_BEEF}}, 1);
    wait_idle("write", 30);

    // m0 abandons mid-transaction; rr_ptr still moves on to 1
    ack_delay = 4;
    issue(0, 1'b0, 32'h3000, '0);
    expect_txn(0, 1'b0, 32'h3000, '0, 2);
    wait_stb("abandon_stb", 10);
    tick();
    bus.m_cyc_i[0] = 1'b0;
    bus.m_stb_i[0] = 1'b0;
    wait_idle("abandon", 30);
    issue(0, 1'b0, 32'h3100, '0);
    issue(1, 1'b0, 32'h3140, '0);
    expect_txn(1, 1'b0, 32'h3140, '0, 0);
    expect_txn(0, 1'b0, 32'h3100, '0, 0);
    wait_idle("after_abandon", 40);

    // reset while BUSY clears outputs at once; the stale ack later is ignored
    ack_delay = 6;
    issue(3, 1'b0, 32'h3800, '0);
    expect_txn(3, 1'b0, 32'h3800, '0, 2);
    wait_stb("rst_stb", 10);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid_s_stb", WS'(bus.s_stb_o), '0);
    chk("rstmid_s_addr", WS'(bus.s_addr_o), '0);
    chk("rstmid_m_data", bus.m_data_o, '0);
    chk("rstmid_busy", WS'(bus.busy_o), '0);
    chk("rstmid_grant", WS'(bus.grant_o), '0);
    bus.m_cyc_i[3] = 1'b0;
    bus.m_stb_i[3] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("stale_ack_idle", WS'(bus.busy_o), '0);

`ifdef DRAM_ARB_TIMEOUT_EN
    // no ack within 16 cycles: err to m1, DRAIN absorbs the late ack
    ack_delay = 20;
    issue(1, 1'b0, 32'h4000, '0);
    expect_txn(1, 1'b0, 32'h4000, '0, 3);
    wait_stb("tmo_stb", 10);
    n = 0;
    while (bus.m_err_o == '0 && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_cycle", WS'(n), WS'(16));
    chk("drain_busy", WS'(bus.busy_o), WS'(1));
    chk("drain_s_stb", WS'(bus.s_stb_o), '0);
    wait_idle("drain", 40);
    ack_delay = 2;
`endif

    chk("exp_s_empty", WS'(exp_s_q.size()), '0);
    chk("exp_m_empty", WS'(exp_m_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
